// File: rtl/ifetch_queue_pkg.sv
// Shared widths, types and defaults for the instruction fetch queue.
// A fetch entry pairs an instruction word with the address it was read from.
package ifetch_queue_pkg;
  localparam int A_BITS     = 8;
  localparam int INSTR_BITS = 16;

  typedef logic [A_BITS-1:0]     addr_t;
  typedef logic [INSTR_BITS-1:0] instr_t;

  typedef struct packed {
    addr_t  pc;
    instr_t instr;
  } fetch_entry_t;

  localparam addr_t RESET_PC_DEFAULT = '0;
endpackage

// File: rtl/ifetch_queue_if.sv
// Fetch-stage bus: program memory port, decode handshake and branch redirect.
// The fetch stage is the master: it drives the PC and the decode-side head entry.
interface ifetch_queue_if;
  import ifetch_queue_pkg::*;

  addr_t  pc;
  instr_t instr;
  logic   if_valid;
  instr_t if_instr;
  addr_t  if_pc;
  logic   id_ready;
  logic   br_taken;
  addr_t  br_target;

  modport master (
    output pc, if_valid, if_instr, if_pc,
    input  instr, id_ready, br_taken, br_target
  );

  modport slave (
    input  pc, if_valid, if_instr, if_pc,
    output instr, id_ready, br_taken, br_target
  );
endinterface

// File: rtl/ifetch_queue_sync_fifo.sv
// Small synchronous FIFO with flush; the head entry is read combinationally
// so a word written at one edge is visible right after it. Reads 0 when empty.
module ifetch_queue_sync_fifo
  import ifetch_queue_pkg::*;
#(
  parameter type T     = fetch_entry_t,
  parameter int  DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  T              wdata,
  output T              rdata,
  output logic [CW-1:0] count
);
  T                mem_reg [DEPTH];
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;

  // Storage carries no reset: slots beyond count are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rdata = (count_reg != '0) ? mem_reg[rd_ptr_reg] : T'('0);
  assign count = count_reg;
endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch stage: owns the PC, prefetches {pc, instr} pairs into a
// queue and hands the head to decode over valid/ready; redirects flush it.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int    DEPTH    = 4,
  parameter addr_t RESET_PC = RESET_PC_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  ifetch_queue_if.master fq
);
  localparam int             CW   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]  FULL = CW'(DEPTH);

  addr_t         pc_reg;
  addr_t         pc_next;
  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  wentry;
  logic          valid;
  logic          pop;
  logic          push;

  assign valid  = (count != '0);
  assign pop    = valid & fq.id_ready;
  // A full queue still accepts a fetch when the head leaves in the same cycle.
  assign push   = ~fq.br_taken & ((count < FULL) | pop);
  assign wentry = '{pc: pc_reg, instr: fq.instr};

  always_comb begin
    pc_next = pc_reg;
    if (fq.br_taken) begin
      pc_next = fq.br_target;
    end else if (push) begin
      pc_next = pc_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_reg <= RESET_PC;
    end else begin
      pc_reg <= pc_next;
    end
  end

  ifetch_queue_sync_fifo #(
    .T     (fetch_entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (fq.br_taken),
    .push  (push),
    .pop   (pop & ~fq.br_taken),
    .wdata (wentry),
    .rdata (head),
    .count (count)
  );

  assign fq.pc       = pc_reg;
  assign fq.if_valid = valid;
  assign fq.if_instr = head.instr;
  assign fq.if_pc    = head.pc;
endmodule
